// File: rtl/spe_noc_pkg.sv
// Shared NoC packet definitions for the SPE injection path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spe_noc_pkg;

  localparam int PKT_WIDTH    = 33;

  // Field bounds inside a single-flit packet
  localparam int ADDR_START   = 32;
  localparam int ADDR_END     = 29;
  localparam int OPCODE_START = 28;
  localparam int OPCODE_END   = 25;
  localparam int DATA_START   = 24;
  localparam int DATA_END     = 0;

  typedef struct packed {
    logic [ADDR_START-ADDR_END:0]     addr;
    logic [OPCODE_START-OPCODE_END:0] opcode;
    logic [DATA_START-DATA_END:0]     data;
  } pkt_t;

endpackage

// File: rtl/spe_inject_arbiter_rr_grant.sv
// Rotate-priority encoder: first set request at or after rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller masks req when the downstream slot is busy.
module rr_grant #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);

  localparam int IW = $clog2(N);

  int          idx;
  logic [IW-1:0] idx_l;

  // Walk the request vector from rr_ptr, keep the first hit
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    idx_l     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_l = IW'(idx);
      if (!any_grant && req[idx_l]) begin
        grant[idx_l] = 1'b1;
        grant_idx    = idx_l;
        any_grant    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spe_inject_arbiter.sv
// Round-robin arbiter sharing one router injection port among NUM_REQ packetizers.
// Latency: packet accepted at edge N is on out_pkt after edge N; 1 pkt/cycle sustained.
// Backpressure: out_ready low holds out_pkt/out_src and drops all req_ready bits.
module spe_inject_arbiter
  import spe_noc_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PKT_WIDTH = spe_noc_pkg::PKT_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PKT_WIDTH-1:0] req_pkt,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [PKT_WIDTH-1:0]         out_pkt,
  input  logic                         out_ready,
  output logic [$clog2(NUM_REQ)-1:0]   out_src,
  input  logic                         clr_cnt,
  output logic [NUM_REQ*CNT_WIDTH-1:0] pkt_cnt
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic                 slot_free;
  logic [NUM_REQ-1:0]   req_masked;
  logic [NUM_REQ-1:0]   grant;
  logic [SRC_W-1:0]     grant_idx;
  logic                 any_grant;
  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     ptr_nxt;
  logic [PKT_WIDTH-1:0] win_pkt;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  // The output register can take a new packet whenever it is empty or draining now
  assign slot_free = !out_valid || out_ready;

  // No grant while busy or while reset is held, so nothing transfers in a reset cycle
  assign req_masked = (slot_free && rst_n) ? req_valid : '0;

  rr_grant #(
    .N (NUM_REQ)
  ) u_rr_grant (
    .req       (req_masked),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  // Pointer advances to the requester after the winner
  assign ptr_nxt = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);

  // Select the winning packet slice
  always_comb begin
    win_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) win_pkt = req_pkt[i*PKT_WIDTH +: PKT_WIDTH];
    end
  end

  // Output pipeline register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pkt   <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (any_grant) begin
      out_valid <= 1'b1;
      out_pkt   <= win_pkt;
      out_src   <= grant_idx;
      rr_ptr    <= ptr_nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating per-requester transfer counters; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_flat
    assign pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q[gi];
  end

endmodule

// File: doc/spe_inject_arbiter.md
Name: spe_inject_arbiter

Overview:
- Clocked round-robin arbiter that shares one NoC router injection port among NUM_REQ processing elements (SPE/PPE packetizer outputs).
- Each requester presents single-flit 33-bit packets: dest addr [32:29], opcode [28:25], data [24:0].
- A one-deep output pipeline register holds the winner until the router accepts it.
- Per-requester saturating packet counters support debug and performance checks.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- PKT_WIDTH, 33, packet width in bits.
- CNT_WIDTH, 16, width of each per-requester accepted-packet counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  bit i high: requester i offers req_pkt slice i.
- req_pkt  in  NUM_REQ*PKT_WIDTH  flattened packets; slice i is [i*PKT_WIDTH +: PKT_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; bit i marks a transfer from requester i this cycle.
- out_valid  out  1  out_pkt holds a packet for the router.
- out_pkt  out  PKT_WIDTH  registered packet.
- out_ready  in  1  router accepts out_pkt this cycle.
- out_src  out  clog2(NUM_REQ)  index of the requester that produced out_pkt.
- clr_cnt  in  1  synchronous clear of all counters.
- pkt_cnt  out  NUM_REQ*CNT_WIDTH  per-requester accepted-packet counts, flattened like req_pkt.

Behaviour:
- Reset (async assert, sync release) sets:
  - out_valid=0, out_pkt=0, out_src=0
  - rr_ptr=0, all pkt_cnt=0
  - req_ready is combinational and therefore reads 0.
- Reset mid-operation discards any held packet; no handshake completes in a reset cycle.
- slot_free = !out_valid || out_ready, combinational. The register accepts a new packet in the same cycle the old one drains.
- Arbitration, combinational, when slot_free:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit g is the grant; req_ready[g]=1 and all other bits are 0.
  - If there is no valid request or slot_free=0, req_ready=0.
- On a clock edge with req_valid[g] && req_ready[g]:
  - out_pkt <= slice g
  - out_src <= g
  - out_valid <= 1
  - rr_ptr <= (g+1) mod NUM_REQ
  - pkt_cnt[g] increments.
- On a clock edge with out_valid && out_ready and no new grant: out_valid <= 0. out_pkt and out_src keep their old values.
- Stall: while out_valid && !out_ready, out_pkt and out_src stay stable and rr_ptr is unchanged.
- Requester rule: once req_valid is asserted, the requester holds it and its packet stable until req_ready. A requester that is not granted this cycle is not penalised; rr_ptr moves only on a transfer.
- Latency: a packet accepted at edge N appears on out_pkt after edge N. Throughput is one packet per cycle when out_ready is held high.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 transfers.
- Counters saturate at 2^CNT_WIDTH-1. If clr_cnt and an increment hit the same cycle, clr_cnt wins and the count becomes 0.
- The packet payload is not inspected or modified. The address and opcode fields pass through unchanged.

Decomposition:
- Package spe_noc_pkg holds:
  - PKT_WIDTH
  - the field-bound constants ADDR_START=32, ADDR_END=29, OPCODE_START=28, OPCODE_END=25, DATA_START=24, DATA_END=0
  - packed struct pkt_t {addr[3:0], opcode[3:0], data[24:0]}.
- One sub-module, rr_grant: purely combinational rotate-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
- The top module holds the output register, rr_ptr and the counters.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, req_ready=0, all pkt_cnt=0 immediately (async). After release, the first grant goes to requester 0.
- Single requester:
  - Stimulus: req 2 sends 0x1_2_0000ABC with out_ready=1.
  - Required: out_pkt=0x1_2_0000ABC and out_src=2 one cycle later; pkt_cnt[2]=1.
- All four valid continuously, out_ready=1, 8 cycles -> grant order 0,1,2,3,0,1,2,3; each pkt_cnt=2; one packet per cycle.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with req 1 and req 3 valid.
  - Required: out_pkt held stable and req_ready=0 throughout. When out_ready=1, the drain and the next grant (to req 3 if req 1 was just served) happen in the same cycle.
- Saturation and clear:
  - Stimulus: CNT_WIDTH=4, 20 packets from req 0.
  - Required: pkt_cnt[0]=15. With clr_cnt asserted in the same cycle as a transfer, the count reads 0.
- Pointer skip: rr_ptr=1, only req 0 valid -> grant 0 after a wrap; rr_ptr becomes 1.
